// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it out MSB first,
// optionally repeating it back-to-back, then pulses done for one cycle.
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_reps,
    output logic             o_x,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_reload;
    logic [CNT_W-1:0] r_reps;
    logic [CNT_W-1:0] r_repcnt;
    logic [BIT_W-1:0] r_bitcnt;
    logic             r_x;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic w_last_bit;
    logic w_more_reps;

    assign w_last_bit  = (r_bitcnt == BIT_W'(WIDTH - 1));
    assign w_more_reps = (r_repcnt < r_reps);

    // Outputs are registered, so the bit shown on o_x is loaded one edge ahead;
    // r_bitcnt indexes the bit currently being presented.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_reload <= '0;
            r_reps   <= '0;
            r_repcnt <= '0;
            r_bitcnt <= '0;
            r_x      <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_x     <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (i_start) begin
                        r_state  <= S_SEND;
                        r_reload <= i_pattern;
                        r_shift  <= {i_pattern[WIDTH-2:0], 1'b0};
                        r_reps   <= i_reps;
                        r_repcnt <= '0;
                        r_bitcnt <= '0;
                        r_x      <= i_pattern[WIDTH-1];
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_stop) begin
                        // Abort wins over everything, including the final bit.
                        r_state  <= S_IDLE;
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_repcnt <= '0;
                        r_x      <= 1'b0;
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                    end else if (w_last_bit) begin
                        if (w_more_reps) begin
                            r_repcnt <= r_repcnt + 1'b1;
                            r_bitcnt <= '0;
                            r_x      <= r_reload[WIDTH-1];
                            r_shift  <= {r_reload[WIDTH-2:0], 1'b0};
                        end else begin
                            r_state <= S_DONE;
                            r_x     <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_x      <= r_shift[WIDTH-1];
                        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_x     <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_x     <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_x     = r_x;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: frames, repeats, ignored start, abort, reset and boundary cases.
module tb_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] pattern;
    logic [3:0] reps;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    seq_gen #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_pattern (pattern),
        .i_reps    (reps),
        .o_x       (x),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge: the start of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input logic [7:0] pat, input logic [3:0] rp,
                             input logic with_stop, input string tag);
        logic [7:0] got;
        int         nbits;
        got     = '0;
        start   = 1'b1;
        stop    = with_stop;
        pattern = pat;
        reps    = rp;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
        pattern = ~pat;
        reps    = 4'h0;
        nbits   = 8 * (int'(rp) + 1);
        for (int i = 0; i < nbits; i++) begin
            got[7 - (i % 8)] = x;
            check({tag, "_valid"}, valid, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_done_lo"}, done, 0);
            if ((i % 8) == 7) check({tag, "_pat"}, got, pat);
            tick();
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_done_valid"}, valid, 0);
        check({tag, "_done_x"}, x, 0);
        check({tag, "_done_busy"}, busy, 1);
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        logic [7:0] got;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        pattern  = 8'h00;
        reps     = 4'h0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("idle");

        run_frame(8'b1100_1011, 4'd0, 1'b0, "basic");
        run_frame(8'b1101_0110, 4'd2, 1'b0, "repeat");

        // start with a new pattern mid-frame must be ignored
        got     = '0;
        start   = 1'b1;
        pattern = 8'b1010_0101;
        reps    = 4'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                start   = 1'b1;
                pattern = 8'hFF;
            end else begin
                start   = 1'b0;
            end
            got[7 - i] = x;
            check("ign_valid", valid, 1);
            tick();
        end
        start = 1'b0;
        check("ign_pat", got, 8'b1010_0101);
        check("ign_done", done, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("ign_no_second");
        end

        // abort at cycle 5 of a two-repetition frame
        start   = 1'b1;
        pattern = 8'h3C;
        reps    = 4'd1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("abort_valid", valid, 1);
            check("abort_x", x, (8'h3C >> (7 - i)) & 8'h01);
            if (i == 4) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        check_idle("abort_c6");
        tick();
        check_idle("abort_c7");
        run_frame(8'h81, 4'd0, 1'b0, "restart");

        // stop on the final bit suppresses done
        start   = 1'b1;
        pattern = 8'hE7;
        reps    = 4'd0;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lastbit_valid", valid, 1);
            if (i == 7) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        check_idle("lastbit_stop");
        tick();
        check_idle("lastbit_stop2");

        // synchronous reset mid-frame
        start   = 1'b1;
        pattern = 8'h96;
        reps    = 4'd3;
        tick();
        start   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_mid");
        tick();
        check_idle("rst_mid_idle");
        run_frame(8'h96, 4'd0, 1'b0, "rst_resend");

        run_frame(8'h5A, 4'hF, 1'b0, "reps_max");
        run_frame(8'hC3, 4'd1, 1'b1, "start_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
